// File: rtl/demux_pkg.sv
// ----------------------------------------------------------------------------
// demux_pkg
// Shared constants and helpers for the 1-to-4 stream demultiplexer.
//   NUM_CH - number of output channels
//   SEL_W  - width of the channel select
//   cnt_w  - width of an occupancy counter able to hold 0..depth inclusive
// ----------------------------------------------------------------------------
package demux_pkg;

    localparam int unsigned NUM_CH = 4;
    localparam int unsigned SEL_W  = 2;

    // One extra bit over the pointer width so that "full" (count == depth)
    // is representable alongside "empty" (count == 0).
    function automatic int unsigned cnt_w(input int unsigned depth);
        return $clog2(depth) + 1;
    endfunction

endpackage

// File: rtl/chan_fifo.sv
// ----------------------------------------------------------------------------
// chan_fifo
// Single-channel synchronous FIFO used as the per-destination buffer of
// demux_router. Read data is taken straight from the storage at the read
// pointer, so a pushed word becomes visible on head one cycle after the
// push edge; there is no pass-through path.
//
// Ports:
//   clk        rising-edge clock
//   rst        asynchronous active-high reset; clears pointers, count, storage
//   push       write push_data this cycle (ignored while full)
//   push_data  word to store
//   pop        consume head this cycle (ignored while empty)
//   empty      count == 0
//   full       count == DEPTH
//   head       word at the read pointer
//   count      current occupancy, 0..DEPTH
// ----------------------------------------------------------------------------
module chan_fifo
    import demux_pkg::*;
#(
    parameter int unsigned DATA_W = 8,
    parameter int unsigned DEPTH  = 2
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      push,
    input  logic [DATA_W-1:0]         push_data,
    input  logic                      pop,
    output logic                      empty,
    output logic                      full,
    output logic [DATA_W-1:0]         head,
    output logic [cnt_w(DEPTH)-1:0]   count
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = cnt_w(DEPTH);

    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(DEPTH);
    localparam logic [PTR_W-1:0] PTR_ONE  = PTR_W'(1);
    localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(DEPTH - 1);

    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]  count_q, count_d;
    logic              do_push, do_pop;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] ptr);
        return (ptr == PTR_LAST) ? '0 : ptr + PTR_ONE;
    endfunction

    assign empty = (count_q == '0);
    assign full  = (count_q == CNT_FULL);

    // Guard locally so the FIFO never over- or under-runs whatever the caller does.
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (do_push) begin
            wr_ptr_d = ptr_inc(wr_ptr_q);
        end
        if (do_pop) begin
            rd_ptr_d = ptr_inc(rd_ptr_q);
        end
        unique case ({do_push, do_pop})
            2'b10:   count_d = count_q + CNT_ONE;
            2'b01:   count_d = count_q - CNT_ONE;
            default: count_d = count_q;
        endcase
    end

    // Storage is reset too so head reads as zero, never X, after reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            for (int i = 0; i < int'(DEPTH); i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            if (do_push) begin
                mem_q[wr_ptr_q] <= push_data;
            end
        end
    end

    assign head  = mem_q[rd_ptr_q];
    assign count = count_q;

endmodule

// File: rtl/demux_router.sv
// ----------------------------------------------------------------------------
// demux_router
// Registered 1-to-4 stream demultiplexer. Each accepted input word is
// steered by in_sel into that channel's FIFO; every channel drains through
// its own valid/ready port. Back-pressure is per channel: a full channel
// only blocks input words addressed to it.
//
// Ports:
//   clk        rising-edge clock
//   rst        asynchronous active-high reset
//   in_valid   producer has a word
//   in_sel     destination channel, qualified by in_valid
//   in_data    word to route
//   in_ready   selected channel has room (depends on in_sel and state only)
//   out_valid  bit k: channel k non-empty
//   out_data   slice k: head word of channel k
//   out_ready  bit k: consumer k takes its head this cycle
//   ch_count   slice k: occupancy of channel k
// ----------------------------------------------------------------------------
module demux_router
    import demux_pkg::*;
#(
    parameter int unsigned DATA_W = 8,
    parameter int unsigned DEPTH  = 2
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic                              in_valid,
    input  logic [SEL_W-1:0]                  in_sel,
    input  logic [DATA_W-1:0]                 in_data,
    output logic                              in_ready,
    output logic [NUM_CH-1:0]                 out_valid,
    output logic [NUM_CH*DATA_W-1:0]          out_data,
    input  logic [NUM_CH-1:0]                 out_ready,
    output logic [NUM_CH*cnt_w(DEPTH)-1:0]    ch_count
);

    localparam int unsigned CNT_W = cnt_w(DEPTH);

    logic [NUM_CH-1:0] push;
    logic [NUM_CH-1:0] full;
    logic [NUM_CH-1:0] empty;
    logic [DATA_W-1:0] head  [NUM_CH];
    logic [CNT_W-1:0]  count [NUM_CH];

    // Registered full flag only: a channel that pops this cycle still refuses
    // a push, which keeps out_ready off the in_ready path.
    assign in_ready = !full[in_sel];

    always_comb begin
        push = '0;
        if (in_valid && in_ready) begin
            push[in_sel] = 1'b1;
        end
    end

    for (genvar k = 0; k < NUM_CH; k++) begin : g_chan
        chan_fifo #(
            .DATA_W (DATA_W),
            .DEPTH  (DEPTH)
        ) u_chan (
            .clk       (clk),
            .rst       (rst),
            .push      (push[k]),
            .push_data (in_data),
            .pop       (out_ready[k]),
            .empty     (empty[k]),
            .full      (full[k]),
            .head      (head[k]),
            .count     (count[k])
        );

        assign out_valid[k]                    = !empty[k];
        assign out_data[k*DATA_W +: DATA_W]    = head[k];
        assign ch_count[k*CNT_W +: CNT_W]      = count[k];
    end

endmodule

// File: tb/tb_demux_router.sv
module tb_demux_router;

    localparam int unsigned DATA_W = 8;
    localparam int unsigned DEPTH  = 2;
    localparam int unsigned NCH    = 4;
    localparam int unsigned CW     = 2;

    logic                  clk = 1'b0;
    logic                  rst = 1'b0;
    logic                  in_valid = 1'b0;
    logic [1:0]            in_sel = 2'd0;
    logic [DATA_W-1:0]     in_data = '0;
    logic                  in_ready;
    logic [NCH-1:0]        out_valid;
    logic [NCH*DATA_W-1:0] out_data;
    logic [NCH-1:0]        out_ready = '0;
    logic [NCH*CW-1:0]     ch_count;

    int n_cmp = 0;
    int n_bad = 0;

    // Reference model: one queue per channel, front = head.
    logic [DATA_W-1:0] mq [NCH][$];

    always #5 clk = ~clk;

    demux_router #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_sel    (in_sel),
        .in_data   (in_data),
        .in_ready  (in_ready),
        .out_valid (out_valid),
        .out_data  (out_data),
        .out_ready (out_ready),
        .ch_count  (ch_count)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Model update: acceptance is judged on occupancy before this edge's pops.
    always @(posedge clk or posedge rst) begin
        logic       take;
        logic [1:0] s;
        if (rst) begin
            for (int k = 0; k < NCH; k++) mq[k].delete();
        end else begin
            s    = in_sel;
            take = in_valid && (mq[s].size() < DEPTH);
            for (int k = 0; k < NCH; k++) begin
                if (out_ready[k] && mq[k].size() != 0) void'(mq[k].pop_front());
            end
            if (take) mq[s].push_back(in_data);
        end
    end

    // Every-cycle comparison against the model, away from the active edge.
    always @(negedge clk) begin
        logic [NCH-1:0]    ev;
        logic [NCH*CW-1:0] ec;
        ev = '0;
        ec = '0;
        for (int k = 0; k < NCH; k++) begin
            ev[k]          = (mq[k].size() != 0);
            ec[k*CW +: CW] = CW'(mq[k].size());
        end
        check("in_ready", {31'd0, in_ready}, {31'd0, mq[in_sel].size() < DEPTH});
        check("out_valid", {28'd0, out_valid}, {28'd0, ev});
        check("ch_count", {24'd0, ch_count}, {24'd0, ec});
        for (int k = 0; k < NCH; k++) begin
            if (ev[k]) check($sformatf("out_data[%0d]", k), {24'd0, out_data[k*DATA_W +: DATA_W]},
                             {24'd0, mq[k][0]});
        end
    end

    // Drive one cycle of inputs, let the edge consume them, return 2 time units after it.
    task automatic step(input logic v, input logic [1:0] s, input logic [7:0] d,
                        input logic [3:0] r);
        in_valid  = v;
        in_sel    = s;
        in_data   = d;
        out_ready = r;
        @(posedge clk);
        #2;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected $finish");
        $fatal(1);
    end

    initial begin
        #1 rst = 1'b1;
        repeat (2) @(posedge clk);
        #2 rst = 1'b0;

        // Reset state
        check("rst in_ready", {31'd0, in_ready}, 32'd1);
        check("rst out_valid", {28'd0, out_valid}, 32'd0);
        check("rst ch_count", {24'd0, ch_count}, 32'd0);
        check("rst out_data", out_data, 32'd0);

        // One word per channel
        step(1'b1, 2'd0, 8'hA0, 4'h0);
        check("first latency", {28'd0, out_valid}, 32'h1);
        step(1'b1, 2'd1, 8'hA1, 4'h0);
        step(1'b1, 2'd2, 8'hA2, 4'h0);
        step(1'b1, 2'd3, 8'hA3, 4'h0);
        check("route valid", {28'd0, out_valid}, 32'hF);
        check("route data", out_data, 32'hA3A2A1A0);
        check("route count", {24'd0, ch_count}, 32'h55);
        step(1'b0, 2'd0, 8'h00, 4'hF);
        check("drain all", {28'd0, out_valid}, 32'h0);

        // Fill channel 2, third word blocked, other channel still accepted
        step(1'b1, 2'd2, 8'h11, 4'h0);
        step(1'b1, 2'd2, 8'h22, 4'h0);
        in_valid = 1'b1; in_sel = 2'd2; in_data = 8'h33; out_ready = 4'h0;
        #1 check("ch2 full ready", {31'd0, in_ready}, 32'd0);
        step(1'b1, 2'd2, 8'h33, 4'h0);
        check("ch2 reject count", {24'd0, ch_count}, 32'h20);
        check("ch2 head", {24'd0, out_data[23:16]}, 32'h11);
        step(1'b1, 2'd1, 8'h44, 4'h0);
        check("ch1 accept count", {24'd0, ch_count}, 32'h24);
        check("ch1 head", {24'd0, out_data[15:8]}, 32'h44);
        step(1'b0, 2'd0, 8'h00, 4'hF);
        check("ch2 second", {24'd0, out_data[23:16]}, 32'h22);
        check("ch2 pop count", {24'd0, ch_count}, 32'h10);
        step(1'b0, 2'd0, 8'h00, 4'hF);

        // Simultaneous push/pop on channel 0 across pointer wrap
        step(1'b1, 2'd0, 8'h01, 4'h0);
        check("ch0 head 01", {24'd0, out_data[7:0]}, 32'h01);
        for (int d = 2; d <= 6; d++) begin
            step(1'b1, 2'd0, 8'(d), 4'h1);
            check($sformatf("pushpop count %0d", d), {24'd0, ch_count}, 32'h01);
            check($sformatf("pushpop head %0d", d), {24'd0, out_data[7:0]}, d);
        end
        step(1'b0, 2'd0, 8'h00, 4'h1);
        check("ch0 drained", {28'd0, out_valid}, 32'h0);

        // Full channel 3 popping while a push arrives: push still refused
        step(1'b1, 2'd3, 8'hB1, 4'h0);
        step(1'b1, 2'd3, 8'hB2, 4'h0);
        in_valid = 1'b1; in_sel = 2'd3; in_data = 8'hB3; out_ready = 4'h8;
        #1 check("ch3 full ready", {31'd0, in_ready}, 32'd0);
        step(1'b1, 2'd3, 8'hB3, 4'h8);
        check("ch3 pop count", {24'd0, ch_count}, 32'h40);
        check("ch3 head", {24'd0, out_data[31:24]}, 32'hB2);
        step(1'b1, 2'd3, 8'hB3, 4'h0);
        check("ch3 retry count", {24'd0, ch_count}, 32'h80);
        step(1'b0, 2'd0, 8'h00, 4'h8);
        check("ch3 retry head", {24'd0, out_data[31:24]}, 32'hB3);
        step(1'b0, 2'd0, 8'h00, 4'h8);

        // Reset with words buffered
        step(1'b1, 2'd0, 8'hC0, 4'h0);
        step(1'b1, 2'd1, 8'hC1, 4'h0);
        step(1'b1, 2'd2, 8'hC2, 4'h0);
        in_valid = 1'b0;
        check("pre-reset valid", {28'd0, out_valid}, 32'h7);
        #1 rst = 1'b1;
        #1 check("async rst valid", {28'd0, out_valid}, 32'h0);
        check("async rst count", {24'd0, ch_count}, 32'h0);
        @(posedge clk);
        #2 rst = 1'b0;
        step(1'b1, 2'd1, 8'hD1, 4'h0);
        check("post-rst valid", {28'd0, out_valid}, 32'h2);
        check("post-rst data", out_data, 32'h0000D100);
        check("post-rst count", {24'd0, ch_count}, 32'h04);
        step(1'b0, 2'd0, 8'h00, 4'h0);
        step(1'b0, 2'd0, 8'h00, 4'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/demux_router.md
# demux_router

Registered 1-to-4 stream demultiplexer: the receive-side counterpart of the team's 4:1 select mux. A single input stream carries a data word and a 2-bit channel select. Each accepted word is steered into a small per-channel FIFO, and each channel drains independently through its own valid/ready port. It sits between a shared producer and four independent consumers, so back-pressure on one channel stalls only input words addressed to that channel.

## Interface
Parameters:
- DATA_W, 8, width of the data word
- DEPTH, 2, entries per channel FIFO (power of two, ≥2)

Ports:
- clk  input  1  single clock, rising-edge
- rst  input  1  reset, asynchronous and active-high
- in_valid  input  1  producer has a word
- in_sel  input  2  destination channel (0..3), qualified by in_valid
- in_data  input  DATA_W  word to route
- in_ready  output  1  word is accepted this cycle when in_valid && in_ready
- out_valid  output  4  bit k: channel k FIFO non-empty
- out_data  output  4*DATA_W  slice k = head word of channel k
- out_ready  input  4  bit k: consumer k takes head this cycle
- ch_count  output  4*($clog2(DEPTH)+1)  per-channel occupancy, for status/debug

## Operation
- in_ready = (count[in_sel] < DEPTH).
  - Combinational from in_sel and registered counts only.
  - No combinational path from out_ready; a full channel does not accept even if it pops the same cycle.
- Push: on in_valid && in_ready, write in_data at wr_ptr[in_sel], increment that wr_ptr (wraps mod DEPTH) and that count.
- Pop on channel k: on out_valid[k] && out_ready[k], increment rd_ptr[k] (wraps mod DEPTH) and decrement count[k].
- Simultaneous push and pop on the same channel: count unchanged, both pointers advance.
- Push to channel j and pops on other channels in the same cycle are fully independent.
- out_valid[k] = (count[k] != 0).
- out_data slice k = mem[k][rd_ptr[k]].
  - Value is don't-care when out_valid[k] = 0, but must not be X after reset.
- Order preserved per channel. No ordering guarantee across channels.
- in_sel, in_data may change freely while in_valid = 0. No "sticky" selection; each word is routed on its own in_sel.

## Timing
- Reset (async assert, release sampled on clk):
  - all counts and pointers = 0
  - out_valid = 4'b0000
  - out_data = 0
  - in_ready = 1
  - ch_count = 0
- Reset mid-operation discards all buffered words immediately; out_valid drops asynchronously.
- Latency: a word accepted at edge N is visible on out_valid/out_data of its channel after edge N (i.e. in cycle N+1). No zero-cycle pass-through.
- Throughput: 1 word/cycle into any non-full channel. Each channel drains 1 word/cycle.
- A full channel blocks only input words with in_sel equal to that channel.
- Full: count = DEPTH, in_ready low for that sel. Empty: count = 0, out_valid low, out_ready ignored.
- Pointer wrap: DEPTH-1 → 0.
- ch_count is registered; it reflects the state after the last edge.

## Structure
- Package demux_pkg:
  - NUM_CH = 4
  - SEL_W = 2
  - function cnt_w(depth) returning $clog2(depth)+1
- Sub-module chan_fifo (DATA_W, DEPTH), instantiated NUM_CH times via generate.
  - Ports: clk, rst, push, push_data, pop, empty, full, head, count.
- Top level holds only the select decode, the in_ready mux and output packing.

## Test plan
- Reset release, no traffic:
  - in_ready=1, out_valid=0000, all ch_count=0.
- Route one word per channel (sel 0..3, data 8'hA0..8'hA3), all out_ready=0:
  - out_valid=1111 one cycle after each push.
  - slice k = 8'hA0+k.
  - each ch_count=1.
- Fill channel 2 with 8'h11, 8'h22, out_ready[2]=0:
  - third word with sel=2 sees in_ready=0 and is not taken.
  - an immediate word with sel=1 is accepted.
- Same-cycle push and pop on channel 0 with count=1:
  - count stays 1.
  - head advances to the new word on the next cycle.
  - FIFO order holds across 6 wrap-around pushes (8'h01..8'h06).
- Channel 3 full with out_ready[3]=1 and a push to sel=3 in the same cycle:
  - in_ready=0, push rejected, count drops to 1.
  - retry next cycle is accepted.
- Assert rst with 3 words buffered across channels:
  - out_valid goes 0000 asynchronously.
  - after release, a new word to sel=1 appears alone, with no stale data.
